// File: rtl/bus_arbiter.sv
// Two-master arbiter in front of one shared memory port. The winner's command is
// latched at grant; a per-access timer aborts transfers the memory never acknowledges.
module bus_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [XLEN-1:0]   m0_addr,
  input  logic [XLEN-1:0]   m0_wdata,
  input  logic [XLEN/8-1:0] m0_wstrb,
  output logic              m0_ack,
  output logic [XLEN-1:0]   m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [XLEN-1:0]   m1_addr,
  input  logic [XLEN-1:0]   m1_wdata,
  input  logic [XLEN/8-1:0] m1_wstrb,
  output logic              m1_ack,
  output logic [XLEN-1:0]   m1_rdata,
  output logic              m1_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int SW = XLEN / 8;
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                 state_q;
  logic                   last_gnt_q;
  logic                   owner_q;
  logic [7:0]             timer_q;
  logic                   mem_req_q;
  logic                   mem_we_q;
  logic [XLEN-1:0]        mem_addr_q;
  logic [XLEN-1:0]        mem_wdata_q;
  logic [SW-1:0]          mem_wstrb_q;
  logic [1:0]             ack_q;
  logic [1:0]             err_q;
  logic [1:0][XLEN-1:0]   rdata_q;

  logic                   win_d;
  logic                   we_d;
  logic [XLEN-1:0]        addr_d;
  logic [XLEN-1:0]        wdata_d;
  logic [SW-1:0]          wstrb_d;

  // On a tie the master that was not granted last wins (1 = m1).
  always_comb begin
    win_d = m1_req;
    if (m0_req && m1_req) begin
      win_d = ~last_gnt_q;
    end
    we_d    = win_d ? m1_we    : m0_we;
    addr_d  = win_d ? m1_addr  : m0_addr;
    wdata_d = win_d ? m1_wdata : m0_wdata;
    wstrb_d = win_d ? m1_wstrb : m0_wstrb;
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      owner_q     <= 1'b0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      ack_q       <= '0;
      err_q       <= '0;
      rdata_q     <= '0;
    end else begin
      ack_q   <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (m0_req || m1_req) begin
            state_q     <= ACCESS;
            owner_q     <= win_d;
            last_gnt_q  <= win_d;
            timer_q     <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= we_d;
            mem_addr_q  <= addr_d;
            mem_wdata_q <= wdata_d;
            mem_wstrb_q <= wstrb_d;
          end
        end
        ACCESS: begin
          // A memory ack in the final timer cycle still counts as success.
          if (mem_ack) begin
            state_q          <= RESP;
            mem_req_q        <= 1'b0;
            ack_q[owner_q]   <= 1'b1;
            rdata_q[owner_q] <= mem_we_q ? '0 : mem_rdata;
          end else if (timer_q == TIMEOUT_C) begin
            state_q        <= RESP;
            mem_req_q      <= 1'b0;
            ack_q[owner_q] <= 1'b1;
            err_q[owner_q] <= 1'b1;
          end else begin
            timer_q <= timer_q + 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign m0_ack    = ack_q[0];
  assign m1_ack    = ack_q[1];
  assign m0_err    = err_q[0];
  assign m1_err    = err_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];

endmodule
